// File: rtl/uart_disp_pkg.sv
// Shared constants for the UART hex scan display: active-high glyph table,
// the blank segment pattern and a width helper for counters and indices.
package uart_disp_pkg;

  localparam logic [6:0] SEG_OFF = 7'b0000000;

  // {G,F,E,D,C,B,A}, lit = 1; lowercase b and d keep them distinct from 8 and 0
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic int bits_for(input int max_value);
    return (max_value < 2) ? 1 : $clog2(max_value + 1);
  endfunction

endpackage

// File: rtl/hex_to_seven_seg.sv
// Combinational nibble to seven-segment decoder, active-high segments.
module hex_to_seven_seg
  import uart_disp_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] segments
);

  assign segments = HEX_SEG[nibble];

endmodule

// File: rtl/uart_hex_scan_display.sv
// Captures received bytes into a nibble history buffer and time-multiplexes
// it onto a common-anode seven-segment bank with ghost blanking.
module uart_hex_scan_display
  import uart_disp_pkg::*;
#(
  parameter int NUM_DIGITS     = 8,
  parameter int CLKS_PER_DIGIT = 125000,
  parameter int BLANK_CLKS     = 16,
  parameter bit ACTIVE_LOW     = 1'b1
) (
  input  logic                              i_Clk,
  input  logic                              i_Rst,
  input  logic                              i_RX_DV,
  input  logic [7:0]                        i_RX_Byte,
  input  logic                              i_Clear,
  input  logic                              i_Blank_Leading,
  output logic [6:0]                        o_Segment,
  output logic [NUM_DIGITS-1:0]             o_Anode,
  output logic [$clog2(NUM_DIGITS+1)-1:0]   o_Digit_Count
);

  localparam int CW = $clog2(NUM_DIGITS + 1);
  localparam int SW = bits_for(CLKS_PER_DIGIT - 1);
  localparam int IW = bits_for(NUM_DIGITS - 1);

  logic [3:0]            digits [NUM_DIGITS];
  logic [CW-1:0]         count;
  logic [SW-1:0]         scan_cnt;
  logic [IW-1:0]         index;

  logic [3:0]            nibble_sel;
  logic [6:0]            seg_raw;
  logic                  loaded_nonzero;
  logic                  digit_blank;
  logic                  in_blank;
  logic [NUM_DIGITS-1:0] anode_drive;
  logic [6:0]            seg_drive;

  // Clear has priority so a byte arriving with it is dropped
  always_ff @(posedge i_Clk) begin
    if (i_Rst || i_Clear) begin
      for (int k = 0; k < NUM_DIGITS; k++) digits[k] <= 4'd0;
      count <= '0;
    end else if (i_RX_DV) begin
      for (int k = NUM_DIGITS - 1; k >= 2; k--) digits[k] <= digits[k-2];
      digits[1] <= i_RX_Byte[7:4];
      digits[0] <= i_RX_Byte[3:0];
      count <= (count >= CW'(NUM_DIGITS - 2)) ? CW'(NUM_DIGITS) : count + CW'(2);
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      scan_cnt <= '0;
      index    <= '0;
    end else if (scan_cnt == SW'(CLKS_PER_DIGIT - 1)) begin
      scan_cnt <= '0;
      index    <= (index == IW'(NUM_DIGITS - 1)) ? '0 : index + IW'(1);
    end else begin
      scan_cnt <= scan_cnt + SW'(1);
    end
  end

  assign nibble_sel = digits[index];

  hex_to_seven_seg u_decode (
    .nibble   (nibble_sel),
    .segments (seg_raw)
  );

  // A digit is a leading zero when nothing loaded at or above it is nonzero
  always_comb begin
    loaded_nonzero = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (k >= int'(index) && k < int'(count) && digits[k] != 4'd0)
        loaded_nonzero = 1'b1;
    end
  end

  assign digit_blank = (int'(index) >= int'(count)) ||
                       (i_Blank_Leading && (index != '0) && !loaded_nonzero);
  assign in_blank    = (scan_cnt < SW'(BLANK_CLKS));
  assign anode_drive = in_blank ? '0 : (NUM_DIGITS'(1) << index);
  assign seg_drive   = (in_blank || digit_blank) ? SEG_OFF : seg_raw;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      o_Anode       <= ACTIVE_LOW ? '1 : '0;
      o_Segment     <= ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;
      o_Digit_Count <= '0;
    end else begin
      o_Anode       <= ACTIVE_LOW ? ~anode_drive : anode_drive;
      o_Segment     <= ACTIVE_LOW ? ~seg_drive : seg_drive;
      o_Digit_Count <= count;
    end
  end

endmodule
